// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: decoder mode encodings and the one-hot helper.
// No ports; imported by the decoder sub-module and by step_decoder_n.
package cpu_pkg;

  // Mode encodings for step/timing decoders.
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // Widest index any decoder may use with onehot(); callers truncate the result.
  localparam int unsigned MAX_SEL_W    = 8;
  localparam int unsigned ONEHOT_MAX_W = 1 << MAX_SEL_W;

  // Returns 1 << idx at the widest supported width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    onehot = ONEHOT_MAX_W'(1) << idx;
  endfunction

endpackage : cpu_pkg

// File: rtl/onehot_dec_n.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
// Ports:
//   idx  in  SEL_W     index to decode
//   en   in  1         0 forces all outputs low
//   d    out 2^SEL_W   one-hot decode of idx (or zero)
module onehot_dec_n
  import cpu_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]         idx,
  input  logic                     en,
  output logic [(1 << SEL_W)-1:0]  d
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  // The shared helper works at maximum width; this guards the index extension.
  if (SEL_W > MAX_SEL_W || SEL_W == 0) begin : g_width_check
    $error("onehot_dec_n: SEL_W must be in 1..MAX_SEL_W");
  end

  // Decode, blanked when disabled.
  always_comb begin
    d = '0;
    if (en) begin
      d = OUT_W'(onehot(MAX_SEL_W'(idx)));
    end
  end

endmodule : onehot_dec_n

// File: rtl/step_decoder_n.sv
// Registered step/timing decoder: holds a select index and drives its one-hot
// decode. Supports hold, step with programmable wrap point, load and clear.
// Ports:
//   clk   in  1        system clock, rising edge
//   rst   in  1        asynchronous active-high reset
//   en    in  1        output enable; 0 blanks d on the next edge, sel still moves
//   mode  in  2        00 hold, 01 step, 10 load, 11 clear
//   w     in  SEL_W    load index, used only in load mode
//   d     out 2^SEL_W  registered one-hot of sel, gated by en
//   sel   out SEL_W    registered current index
//   wrap  out 1        one-cycle pulse when step goes LAST_STEP -> 0
//   err   out 1        one-cycle pulse when a load index exceeds LAST_STEP
module step_decoder_n
  import cpu_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned LAST_STEP = (1 << SEL_W) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         w,
  output logic [(1 << SEL_W)-1:0]  d,
  output logic [SEL_W-1:0]         sel,
  output logic                     wrap,
  output logic                     err
);

  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_STEP);

  if (LAST_STEP > OUT_W - 1) begin : g_last_check
    $error("step_decoder_n: LAST_STEP exceeds 2^SEL_W-1");
  end

  logic [SEL_W-1:0] sel_next;
  logic [OUT_W-1:0] d_next;
  logic             wrap_next;
  logic             err_next;

  // Next index and pulse flags from the current mode.
  always_comb begin
    sel_next  = sel;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    case (mode)
      MODE_STEP: begin
        if (sel == LAST) begin
          sel_next  = '0;
          wrap_next = 1'b1;
        end else begin
          sel_next = sel + SEL_W'(1);
        end
      end
      MODE_LOAD: begin
        // Out-of-range loads keep the old index and flag the attempt.
        if (w > LAST) begin
          err_next = 1'b1;
        end else begin
          sel_next = w;
        end
      end
      MODE_CLEAR: begin
        sel_next = '0;
      end
      default: begin
        sel_next = sel;
      end
    endcase
  end

  // Decoding sel_next keeps d aligned with the sel registered on the same edge.
  onehot_dec_n #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx (sel_next),
    .en  (en),
    .d   (d_next)
  );

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel  <= '0;
      d    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      sel  <= sel_next;
      d    <= d_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end

endmodule : step_decoder_n
